// File: rtl/snake_game_ctrl_if.sv
// Signal bundle between the snake game controller (master) and its
// input/debounce and snake datapath neighbours (slave).
interface snake_game_ctrl_if;
  logic       start;
  logic       pause;
  logic       slow;
  logic       dir_valid;
  logic [1:0] dir_req;
  logic       hit_boundary;
  logic       hit_self;
  logic       get_food;
  logic [5:0] snake_length;
  logic [1:0] game_state;
  logic [1:0] next_direction;
  logic       step;
  logic       food_req;
  logic [7:0] score;
  logic       win;

  modport master (
    input  start, pause, slow, dir_valid, dir_req,
    input  hit_boundary, hit_self, get_food, snake_length,
    output game_state, next_direction, step, food_req, score, win
  );

  modport slave (
    output start, pause, slow, dir_valid, dir_req,
    output hit_boundary, hit_self, get_food, snake_length,
    input  game_state, next_direction, step, food_req, score, win
  );
endinterface

// File: rtl/snake_game_ctrl.sv
// Snake game-flow controller: game FSM, move tick, direction filter and score.
// Optional feature macro SNAKE_SPEEDUP_EN: move period shrinks as the score grows.
module snake_game_ctrl #(
  parameter int TICK_FAST    = 25_000_000,
  parameter int TICK_SLOW    = 50_000_000,
  parameter int TICK_MIN     = 5_000_000,
  parameter int SPEEDUP_STEP = 1_000_000,
  parameter int MAX_LEN      = 63
) (
  input logic               clk,
  input logic               rst_n,
  snake_game_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    ST_RUNNING = 2'b00,
    ST_DIE     = 2'b01,
    ST_INITIAL = 2'b10,
    ST_PAUSED  = 2'b11
  } state_e;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [5:0] MAX_LEN_L = 6'(MAX_LEN);
`ifdef SNAKE_SPEEDUP_EN
  localparam logic SPEEDUP_ON = 1'b1;
`else
  localparam logic SPEEDUP_ON = 1'b0;
`endif

  state_e      state_r, state_s;
  logic [31:0] cnt_r, cnt_s;
  logic [31:0] cut_s, fast_s, period_s, period_m1_s;
  logic        step_r, step_s;
  logic        food_req_r, food_req_s;
  logic        win_r, win_s;
  logic [1:0]  dir_r, dir_s;
  logic [1:0]  pend_dir_r, pend_dir_s;
  logic        pend_vld_r, pend_vld_s;
  logic [7:0]  score_r, score_s;
  logic        start_d_r, food_d_r;
  logic        start_rise_s, food_ok_s, dir_ok_s, collide_s, full_s, win_hit_s;

  assign start_rise_s = bus.start & ~start_d_r;
  assign food_ok_s    = bus.get_food & ~food_d_r & (state_r == ST_RUNNING);
  assign collide_s    = bus.hit_boundary | bus.hit_self;
  assign full_s       = (bus.snake_length >= MAX_LEN_L);
  assign win_hit_s    = (state_r == ST_RUNNING) & ~collide_s & full_s;
  // A request that exactly reverses the committed direction is dropped (UP^1=DOWN, RIGHT^1=LEFT)
  assign dir_ok_s     = bus.dir_valid &
                        ((state_r == ST_RUNNING) | (state_r == ST_PAUSED)) &
                        (bus.dir_req != (dir_r ^ 2'b01));

  // Move period for the current speed setting
  always_comb begin
    cut_s  = 32'd0;
    fast_s = 32'(TICK_FAST);
    if (SPEEDUP_ON) begin
      cut_s = 32'(score_r) * 32'(SPEEDUP_STEP);
      if (cut_s + 32'(TICK_MIN) >= 32'(TICK_FAST)) fast_s = 32'(TICK_MIN);
      else fast_s = 32'(TICK_FAST) - cut_s;
    end else begin
      cut_s = 32'd0;
    end
    if (!bus.slow) period_s = fast_s;
    else if (SPEEDUP_ON) period_s = fast_s << 1;
    else period_s = 32'(TICK_SLOW);
  end

  assign period_m1_s = period_s - 32'd1;

  // Game state next-state logic; collision beats win beats pause
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_INITIAL: begin
        if (start_rise_s) state_s = ST_RUNNING;
        else state_s = ST_INITIAL;
      end
      ST_RUNNING: begin
        if (collide_s) state_s = ST_DIE;
        else if (full_s) state_s = ST_DIE;
        else if (bus.pause) state_s = ST_PAUSED;
        else state_s = ST_RUNNING;
      end
      ST_PAUSED: begin
        if (bus.pause) state_s = ST_PAUSED;
        else state_s = ST_RUNNING;
      end
      ST_DIE: begin
        if (start_rise_s) state_s = ST_INITIAL;
        else state_s = ST_DIE;
      end
      default: state_s = ST_INITIAL;
    endcase
  end

  // Tick counter, direction commit, score and pulse next-values
  always_comb begin
    cnt_s      = cnt_r;
    pend_vld_s = pend_vld_r;
    pend_dir_s = pend_dir_r;
    dir_s      = dir_r;
    score_s    = score_r;
    win_s      = win_r;
    if (state_s == ST_INITIAL) begin
      cnt_s      = 32'd0;
      pend_vld_s = 1'b0;
      pend_dir_s = DIR_UP;
      dir_s      = DIR_UP;
      score_s    = 8'd0;
      win_s      = 1'b0;
    end else begin
      // Clamping at P-1 makes a shortened period fire on the next cycle
      if (state_r == ST_RUNNING) begin
        if (step_r) cnt_s = 32'd0;
        else if (cnt_r >= period_m1_s) cnt_s = period_m1_s;
        else cnt_s = cnt_r + 32'd1;
      end else if (state_r == ST_INITIAL) begin
        cnt_s = 32'd0;
      end else begin
        cnt_s = cnt_r;
      end
      if (step_r) begin
        pend_vld_s = 1'b0;
        pend_dir_s = DIR_UP;
        if (dir_ok_s) dir_s = bus.dir_req;
        else if (pend_vld_r) dir_s = pend_dir_r;
        else dir_s = dir_r;
      end else if (dir_ok_s) begin
        pend_vld_s = 1'b1;
        pend_dir_s = bus.dir_req;
      end else begin
        pend_vld_s = pend_vld_r;
      end
      if (food_ok_s && (score_r != 8'hFF)) score_s = score_r + 8'd1;
      else score_s = score_r;
      if (win_hit_s) win_s = 1'b1;
      else win_s = win_r;
    end
    step_s     = (state_s == ST_RUNNING) && (cnt_s == period_m1_s);
    food_req_s = food_ok_s && (state_s == ST_RUNNING);
  end

  // Game state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_INITIAL;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r      <= 32'd0;
      step_r     <= 1'b0;
      food_req_r <= 1'b0;
      win_r      <= 1'b0;
      dir_r      <= DIR_UP;
      pend_dir_r <= DIR_UP;
      pend_vld_r <= 1'b0;
      score_r    <= 8'd0;
      start_d_r  <= 1'b0;
      food_d_r   <= 1'b0;
    end else begin
      cnt_r      <= cnt_s;
      step_r     <= step_s;
      food_req_r <= food_req_s;
      win_r      <= win_s;
      dir_r      <= dir_s;
      pend_dir_r <= pend_dir_s;
      pend_vld_r <= pend_vld_s;
      score_r    <= score_s;
      start_d_r  <= bus.start;
      food_d_r   <= bus.get_food;
    end
  end

  assign bus.game_state     = state_r;
  assign bus.next_direction = dir_r;
  assign bus.step           = step_r;
  assign bus.food_req       = food_req_r;
  assign bus.score          = score_r;
  assign bus.win            = win_r;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Self-checking bench for snake_game_ctrl: directed scenarios plus randomized
// traffic compared against a behavioural model of the game rules.
module tb_snake_game_ctrl;
  localparam int TF = 4, TS = 8, TMIN = 2, TSTEP = 1, MAXL = 5;
  localparam int S_RUN = 0, S_DIE = 1, S_INIT = 2, S_PAUSE = 3;
  localparam int UP = 0, DOWN = 1, RIGHT = 2, LEFT = 3;

  logic clk = 1'b0;
  logic rst_n;
  snake_game_ctrl_if bus();

  snake_game_ctrl #(.TICK_FAST(TF), .TICK_SLOW(TS), .TICK_MIN(TMIN),
                    .SPEEDUP_STEP(TSTEP), .MAX_LEN(MAXL))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0, cyc = 0;

  // Behavioural model: values describe the cycle currently on the outputs
  int m_state, m_cnt, m_dir, m_pend, m_score;
  bit m_win, m_step, m_food, m_prev_start, m_prev_food;

  function automatic int opposite(input int d);
    case (d)
      UP: return DOWN;
      DOWN: return UP;
      RIGHT: return LEFT;
      default: return RIGHT;
    endcase
  endfunction

  function automatic int period(input bit s, input int sc);
    int f;
`ifdef SNAKE_SPEEDUP_EN
    f = TF - sc * TSTEP;
    if (f < TMIN) f = TMIN;
    return s ? 2 * f : f;
`else
    f = TF + 0 * sc;
    return s ? TS : f;
`endif
  endfunction

  task automatic model_reset();
    m_state = S_INIT; m_cnt = 0; m_dir = UP; m_pend = -1; m_score = 0;
    m_win = 0; m_step = 0; m_food = 0; m_prev_start = 0; m_prev_food = 0;
  endtask

  task automatic model_edge();
    int p, ns, ncnt;
    bit srise, frise, accept;
    if (!rst_n) begin model_reset(); return; end
    p = period(bus.slow, m_score);
    srise = bus.start && !m_prev_start;
    frise = bus.get_food && !m_prev_food;
    accept = bus.dir_valid && (m_state == S_RUN || m_state == S_PAUSE) &&
             int'(bus.dir_req) != opposite(m_dir);
    ns = m_state;
    if (m_state == S_INIT && srise) ns = S_RUN;
    else if (m_state == S_DIE && srise) ns = S_INIT;
    else if (m_state == S_PAUSE && !bus.pause) ns = S_RUN;
    else if (m_state == S_RUN) begin
      if (bus.hit_boundary || bus.hit_self) ns = S_DIE;
      else if (int'(bus.snake_length) >= MAXL) begin ns = S_DIE; m_win = 1; end
      else if (bus.pause) ns = S_PAUSE;
    end
    m_food = (m_state == S_RUN) && frise && (ns == S_RUN);
    if (m_state == S_RUN && frise && m_score < 255) m_score++;
    if (m_step) begin
      if (accept) m_dir = int'(bus.dir_req);
      else if (m_pend >= 0) m_dir = m_pend;
      m_pend = -1;
    end else if (accept) m_pend = int'(bus.dir_req);
    if (m_state == S_RUN) ncnt = m_step ? 0 : ((m_cnt + 1 > p - 1) ? p - 1 : m_cnt + 1);
    else if (m_state == S_INIT) ncnt = 0;
    else ncnt = m_cnt;
    m_step = (ns == S_RUN) && (ncnt == p - 1);
    m_cnt = ncnt;
    if (ns == S_INIT) begin
      m_cnt = 0; m_pend = -1; m_dir = UP; m_score = 0; m_win = 0;
    end
    m_state = ns;
    m_prev_start = bus.start;
    m_prev_food = bus.get_food;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
  endtask

  task automatic set_idle();
    bus.start = 0; bus.pause = 0; bus.slow = 0; bus.dir_valid = 0; bus.dir_req = 2'b00;
    bus.hit_boundary = 0; bus.hit_self = 0; bus.get_food = 0; bus.snake_length = 6'd3;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_idle();
    model_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (bus.game_state !== 2'b10) $display("FAIL rst_state got=%b exp=10", bus.game_state); else n_pass++;
    n_checks++; if (bus.next_direction !== 2'b00) $display("FAIL rst_dir got=%b exp=00", bus.next_direction); else n_pass++;
    n_checks++; if (bus.step !== 1'b0) $display("FAIL rst_step got=%b exp=0", bus.step); else n_pass++;
    n_checks++; if (bus.food_req !== 1'b0) $display("FAIL rst_food_req got=%b exp=0", bus.food_req); else n_pass++;
    n_checks++; if (bus.score !== 8'd0) $display("FAIL rst_score got=%0d exp=0", bus.score); else n_pass++;
    n_checks++; if (bus.win !== 1'b0) $display("FAIL rst_win got=%b exp=0", bus.win); else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_start_step();
    int k, last, first;
    k = cyc;
    bus.start = 1; tick(); bus.start = 0;
    n_checks++; if (bus.game_state !== 2'b00) $display("FAIL start_state got=%b exp=00", bus.game_state); else n_pass++;
    last = -1; first = -1;
    for (int i = 0; i < 24; i++) begin
      n_checks++; if (bus.step !== m_step) $display("FAIL fast_step cyc=%0d got=%b exp=%b", cyc, bus.step, m_step); else n_pass++;
      if (bus.step === 1'b1) begin
        if (first < 0) first = cyc - k;
        else begin
          n_checks++; if (cyc - last != TF) $display("FAIL fast_spacing got=%0d exp=%0d", cyc - last, TF); else n_pass++;
        end
        last = cyc;
      end
      tick();
    end
    n_checks++; if (first != TF) $display("FAIL first_step_delay got=%0d exp=%0d", first, TF); else n_pass++;
    bus.slow = 1; last = -1;
    for (int i = 0; i < 36; i++) begin
      tick();
      n_checks++; if (bus.step !== m_step) $display("FAIL slow_step cyc=%0d got=%b exp=%b", cyc, bus.step, m_step); else n_pass++;
      if (bus.step === 1'b1) begin
        if (last >= 0) begin
          n_checks++; if (cyc - last != TS) $display("FAIL slow_spacing got=%0d exp=%0d", cyc - last, TS); else n_pass++;
        end
        last = cyc;
      end
    end
    for (int i = 0; i < 16 && m_cnt != 6; i++) tick();
    n_checks++; if (m_cnt != 6) $display("FAIL wait_cnt6 got=%0d exp=6", m_cnt); else n_pass++;
    bus.slow = 0; tick();
    n_checks++; if (bus.step !== 1'b1) $display("FAIL slow_to_fast_step got=%b exp=1", bus.step); else n_pass++;
    tick();
    n_checks++; if (bus.step !== 1'b0) $display("FAIL slow_to_fast_wrap got=%b exp=0", bus.step); else n_pass++;
  endtask

  task automatic test_direction();
    for (int i = 0; i < 10 && !m_step; i++) tick();
    n_checks++; if (!m_step) $display("FAIL dir_wait_step got=0 exp=1"); else n_pass++;
    tick();
    bus.dir_valid = 1; bus.dir_req = 2'(DOWN); tick();
    bus.dir_req = 2'(RIGHT); tick();
    bus.dir_valid = 0;
    for (int i = 0; i < 10 && !m_step; i++) tick();
    n_checks++; if (bus.step !== 1'b1 || bus.next_direction !== 2'b00) $display("FAIL dir_before_commit step=%b dir=%b exp step=1 dir=00", bus.step, bus.next_direction); else n_pass++;
    tick();
    n_checks++; if (bus.next_direction !== 2'b10) $display("FAIL dir_commit_right got=%b exp=10", bus.next_direction); else n_pass++;
    for (int i = 0; i < 10 && !m_step; i++) tick();
    bus.dir_valid = 1; bus.dir_req = 2'(LEFT); tick(); bus.dir_valid = 0;
    n_checks++; if (bus.next_direction !== 2'b10) $display("FAIL dir_reverse_drop got=%b exp=10", bus.next_direction); else n_pass++;
    for (int i = 0; i < 10 && !m_step; i++) tick();
    bus.dir_valid = 1; bus.dir_req = 2'(UP); tick(); bus.dir_valid = 0;
    n_checks++; if (bus.next_direction !== 2'b00) $display("FAIL dir_same_cycle got=%b exp=00", bus.next_direction); else n_pass++;
  endtask

  task automatic test_pause();
    for (int i = 0; i < 10 && !(m_cnt == 1 && !m_step); i++) tick();
    bus.pause = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++; if (bus.game_state !== 2'b11 || bus.step !== 1'b0) $display("FAIL pause_hold cyc=%0d state=%b step=%b exp state=11 step=0", cyc, bus.game_state, bus.step); else n_pass++;
    end
    bus.pause = 0; tick();
    n_checks++; if (bus.game_state !== 2'b00 || bus.step !== 1'b0) $display("FAIL resume_1 state=%b step=%b exp state=00 step=0", bus.game_state, bus.step); else n_pass++;
    tick();
    n_checks++; if (bus.step !== 1'b1) $display("FAIL resume_2_step got=%b exp=1", bus.step); else n_pass++;
  endtask

  task automatic test_food();
    int s0;
    s0 = m_score;
    bus.get_food = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (bus.score !== 8'(s0 + 1)) $display("FAIL food_score i=%0d got=%0d exp=%0d", i, bus.score, s0 + 1); else n_pass++;
      n_checks++; if (bus.food_req !== (i == 0)) $display("FAIL food_req i=%0d got=%b exp=%b", i, bus.food_req, i == 0); else n_pass++;
    end
    bus.get_food = 0; tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      bus.dir_valid = ($urandom_range(0, 2) == 0);
      bus.dir_req = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) bus.get_food = ~bus.get_food;
      if ($urandom_range(0, 29) == 0) bus.slow = ~bus.slow;
      if ($urandom_range(0, 19) == 0) bus.pause = ~bus.pause;
      tick();
      n_checks++; if (bus.game_state !== 2'(m_state)) $display("FAIL rnd_state cyc=%0d got=%b exp=%0d", cyc, bus.game_state, m_state); else n_pass++;
      n_checks++; if (bus.step !== m_step) $display("FAIL rnd_step cyc=%0d got=%b exp=%b", cyc, bus.step, m_step); else n_pass++;
      n_checks++; if (bus.next_direction !== 2'(m_dir)) $display("FAIL rnd_dir cyc=%0d got=%b exp=%0d", cyc, bus.next_direction, m_dir); else n_pass++;
      n_checks++; if (bus.food_req !== m_food) $display("FAIL rnd_food_req cyc=%0d got=%b exp=%b", cyc, bus.food_req, m_food); else n_pass++;
      n_checks++; if (bus.score !== 8'(m_score)) $display("FAIL rnd_score cyc=%0d got=%0d exp=%0d", cyc, bus.score, m_score); else n_pass++;
    end
    set_idle();
    repeat (2) tick();
  endtask

  task automatic test_collision();
    for (int i = 0; i < 10 && !(m_state == S_RUN && m_cnt == TF - 2 && !m_step); i++) tick();
    n_checks++; if (m_cnt != TF - 2) $display("FAIL coll_wait got=%0d exp=%0d", m_cnt, TF - 2); else n_pass++;
    bus.hit_self = 1; bus.pause = 1; tick();
    bus.hit_self = 0; bus.pause = 0;
    n_checks++; if (bus.game_state !== 2'b01 || bus.step !== 1'b0) $display("FAIL coll_die state=%b step=%b exp state=01 step=0", bus.game_state, bus.step); else n_pass++;
    tick();
    n_checks++; if (bus.step !== 1'b0 || bus.game_state !== 2'b01) $display("FAIL die_hold state=%b step=%b exp state=01 step=0", bus.game_state, bus.step); else n_pass++;
    bus.start = 1; tick(); bus.start = 0;
    n_checks++; if (bus.game_state !== 2'b10 || bus.score !== 8'd0) $display("FAIL die_to_init state=%b score=%0d exp state=10 score=0", bus.game_state, bus.score); else n_pass++;
    tick();
  endtask

  task automatic test_win();
    bus.start = 1; tick(); bus.start = 0;
    repeat (2) tick();
    bus.snake_length = 6'(MAXL); tick(); bus.snake_length = 6'd3;
    n_checks++; if (bus.game_state !== 2'b01 || bus.win !== 1'b1) $display("FAIL win_die state=%b win=%b exp state=01 win=1", bus.game_state, bus.win); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    bus.start = 1; tick(); bus.start = 0; tick();
    bus.start = 1; tick(); bus.start = 0;
    for (int i = 0; i < 10 && !m_step; i++) tick();
    tick();
    bus.dir_valid = 1; bus.dir_req = 2'(RIGHT); tick(); bus.dir_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.game_state !== 2'b10 || bus.next_direction !== 2'b00 || bus.step !== 1'b0) $display("FAIL async_rst state=%b dir=%b step=%b exp 10/00/0", bus.game_state, bus.next_direction, bus.step); else n_pass++;
    n_checks++; if (bus.score !== 8'd0 || bus.win !== 1'b0 || bus.food_req !== 1'b0) $display("FAIL async_rst_b score=%0d win=%b food_req=%b exp 0/0/0", bus.score, bus.win, bus.food_req); else n_pass++;
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    bus.start = 1; tick(); bus.start = 0;
    repeat (10) tick();
    n_checks++; if (bus.next_direction !== 2'b00) $display("FAIL pend_dropped got=%b exp=00", bus.next_direction); else n_pass++;
    n_checks++; if (bus.step !== m_step) $display("FAIL post_rst_step got=%b exp=%b", bus.step, m_step); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_start_step();
    test_direction();
    test_pause();
    test_food();
    test_random();
    test_collision();
    test_win();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/snake_game_ctrl.md
# snake_game_ctrl

Game-flow controller and move scheduler for the snake datapath. Owns the `game_state` encoding and issues a one-cycle `step` pulse at the configured move rate. Filters player direction requests, including illegal reversals, and commits them at move boundaries. Reacts to the collision/food flags returned by the snake datapath and maintains the score. Sits between the input/debounce logic and the snake body datapath; its outputs also drive the food generator and display.

## Interface
Parameters:
- `TICK_FAST`, default 25_000_000: clocks per move, normal speed.
- `TICK_SLOW`, default 50_000_000: clocks per move while `slow`=1.
- `TICK_MIN`, default 5_000_000: floor period, used only with `SNAKE_SPEEDUP_EN`.
- `SPEEDUP_STEP`, default 1_000_000: period reduction per food, used only with `SNAKE_SPEEDUP_EN`.
- `MAX_LEN`, default 63: length that ends the game as a win.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: debounced button level, rising-edge detected internally.
- `pause`, in, 1: level; 1 requests pause.
- `slow`, in, 1: selects `TICK_SLOW`.
- `dir_valid`, in, 1: direction request strobe.
- `dir_req`, in, 2: requested direction (UP=00, DOWN=01, RIGHT=10, LEFT=11).
- `hit_boundary`, in, 1: wall collision flag from datapath.
- `hit_self`, in, 1: self collision flag from datapath.
- `get_food`, in, 1: food flag from datapath, a level.
- `snake_length`, in, 6: current length.
- `game_state`, out, 2: RUNNING=00, DIE=01, INITIAL=10, PAUSED=11.
- `next_direction`, out, 2: committed move direction.
- `step`, out, 1: one-cycle move pulse.
- `food_req`, out, 1: one-cycle request for new food position.
- `score`, out, 8: foods eaten, saturating at 255.
- `win`, out, 1: set when the game ended by reaching `MAX_LEN`.

## Operation
- FSM state is `game_state`, registered.
  - INITIAL goes to RUNNING on a `start` rising edge.
  - RUNNING goes to PAUSED when `pause`=1.
  - PAUSED goes to RUNNING when `pause`=0.
  - RUNNING goes to DIE when `hit_boundary|hit_self`, or when `snake_length>=MAX_LEN` (this case also sets `win`=1).
  - DIE goes to INITIAL on a `start` rising edge.
- Priority within RUNNING for the same cycle: collision, then win, then pause.
- INITIAL: clears `score`, `win`, the tick counter and the pending direction; sets `next_direction`=UP.
- Tick counter runs only in RUNNING.
  - Period P = `slow` ? `TICK_SLOW` : `TICK_FAST`.
  - Counts 0..P-1; `step`=1 in the cycle the count equals P-1, then the count wraps to 0.
  - Holds its value in PAUSED.
  - Cleared on entry to RUNNING from INITIAL.
  - A change of `slow` takes effect immediately. If count >= new P-1, the next cycle issues `step` and wraps.
- Direction handling:
  - A `dir_valid` request is stored as pending unless it is the exact reverse of `next_direction` (UP/DOWN, LEFT/RIGHT); reversals are dropped.
  - A later valid request overwrites the pending one.
  - On `step`, pending is copied to `next_direction` and pending is cleared.
  - Requests are ignored outside RUNNING/PAUSED.
- Food handling:
  - A rising edge of `get_food` while RUNNING increments `score` (saturating) and pulses `food_req`.
  - A level held across cycles counts once.
- `step`, `food_req` are never asserted outside RUNNING.

## Timing
- Reset values: `game_state`=INITIAL, `next_direction`=UP, `step`=0, `food_req`=0, `score`=0, `win`=0; tick counter, pending direction and edge registers cleared.
- Reset mid-game returns asynchronously to the reset values and drops any pending direction.
- `start` edge at cycle n: `game_state` changes at n+1. The first `step` comes P cycles after entry to RUNNING.
- Collision flag seen at cycle n: DIE at n+1. A `step` is not issued at n+1, even if the tick was due.
- `step` and direction commit happen in the same clock edge. The datapath sees the new `next_direction` from the cycle after `step`.
- `get_food` rise at cycle n: `food_req`=1 and `score`+1 at n+1.
- The `dir_valid` request and the commit at `step` in the same cycle: the request is checked against the old `next_direction` and committed at that same edge.

## Configuration
- `SNAKE_SPEEDUP_EN` defined: fast period = max(`TICK_MIN`, `TICK_FAST` − `score`×`SPEEDUP_STEP`). The slow period is twice that value.
- `SNAKE_SPEEDUP_EN` undefined: fixed `TICK_FAST`/`TICK_SLOW`; `TICK_MIN` and `SPEEDUP_STEP` are unused.

## Test plan
All scenarios use `TICK_FAST`=4, `TICK_SLOW`=8, `MAX_LEN`=5.
- Reset, then `start` pulse: `game_state` goes 10→00 one cycle later. `step` pulses every 4 cycles; with `slow`=1, every 8 cycles.
- `next_direction`=UP, request DOWN then RIGHT before the step: DOWN dropped; `next_direction`=RIGHT after the next `step`.
- `pause`=1 for 10 cycles at counter=2: no `step` during pause. After `pause`=0, `step` comes 2 cycles after resume.
- `get_food` high for 3 cycles: `score` 0→1 once; single `food_req` pulse one cycle after the rise.
- `hit_self`=1 in the same cycle as a due tick and `pause`=1: DIE next cycle, no `step`. A `start` edge then returns to INITIAL with `score`=0.
- `snake_length`=5: DIE with `win`=1. `rst_n` low mid-RUNNING: immediate INITIAL, outputs at reset values.
